event_encoder_25: RTL and testbench



---
 rtl/event_encoder_25_pkg.sv | 18 +
 rtl/event_encoder_25_cell.sv | 28 ++
 rtl/event_encoder_25.sv | 75 +++++++
 tb/tb_event_encoder_25.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/event_encoder_25_pkg.sv
// event_encoder_25_pkg: shared constants, state encoding and sizing helpers for the latency encoder
package event_encoder_25_pkg;
  localparam int N_PIX = 25;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int pix_max(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/event_encoder_25_cell.sv
// event_enc_cell: one pixel register plus registered one-shot spike when MAX-pixel equals the current step
module event_enc_cell #(
  parameter int p_pix_width = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [p_pix_width-1:0] pixel_i,
  input  logic                   fire_en_i,
  input  logic [p_pix_width-1:0] step_i,
  input  logic                   clear_i,
  output logic                   event_o
);
  localparam logic [p_pix_width-1:0] MAXV = '1;
  logic [p_pix_width-1:0] pix_q;
  logic                   ev_q, ev_d;
  always_comb ev_d = !clear_i && fire_en_i && (pix_q != '0) && ((MAXV - pix_q) == step_i);
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      ev_q  <= 1'b0;
    end else begin
      if (load_i) pix_q <= pixel_i;
      ev_q <= ev_d;
    end
  end
  assign event_o = ev_q;
endmodule

// File: rtl/event_encoder_25.sv
// event_encoder_25: 5x5 time-to-first-spike encoder; i_pixels/i_valid/i_clear in, o_event/o_ready/o_busy/o_done out
module event_encoder_25
  import event_encoder_25_pkg::*;
#(
  parameter int p_pix_width = 4,
  parameter int p_tick      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_PIX*p_pix_width-1:0] i_pixels,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_clear,
  output logic [N_PIX:1]               o_event,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int MAX = pix_max(p_pix_width);
  localparam int TW  = (clog2(p_tick) < 1) ? 1 : clog2(p_tick);
  state_e                 state_q, state_d;
  logic [p_pix_width-1:0] step_q, step_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic                   clr, accept, tick_wrap, last_step, fire_en;
  assign clr       = i_clear && (state_q != IDLE);
  assign accept    = (state_q == IDLE) && i_valid && !i_clear;
  assign tick_wrap = tick_q == TW'(p_tick - 1);
  assign last_step = step_q == p_pix_width'(MAX);
  assign fire_en   = (state_q == RUN) && (tick_q == '0);
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tick_d  = tick_q;
    if (clr) begin
      state_d = IDLE;
      step_d  = '0;
      tick_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = accept ? RUN : IDLE;
      step_d  = '0;
      tick_d  = '0;
    end else if (state_q == RUN) begin
      tick_d  = tick_wrap ? '0 : tick_q + 1'b1;
      step_d  = !tick_wrap ? step_q : (last_step ? '0 : step_q + 1'b1);
      state_d = (tick_wrap && last_step) ? DONE : RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
    end
  end
  for (genvar g = 1; g <= N_PIX; g++) begin : g_cell
    event_enc_cell #(.p_pix_width(p_pix_width)) u_cell (
      .clk      (i_clk),
      .rst      (i_rst),
      .load_i   (accept),
      .pixel_i  (i_pixels[g*p_pix_width-1 -: p_pix_width]),
      .fire_en_i(fire_en),
      .step_i   (step_q),
      .clear_i  (clr),
      .event_o  (o_event[g])
    );
  end
  assign o_ready = state_q == IDLE;
  assign o_busy  = state_q == RUN;
  assign o_done  = state_q == DONE;
endmodule

// File: tb/tb_event_encoder_25.sv
// tb_event_encoder_25: scoreboard bench for event_encoder_25 with p_tick=4 and p_tick=1 instances
module tb_event_encoder_25;
  logic          clk = 1'b0;
  logic          rst;
  logic [99:0]   pix1, pix2;
  logic          v1, v2, c1, c2;
  logic          r1, b1, d1, r2, b2, d2;
  logic [25:1]   e1, e2;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            a;
  logic [99:0]   p;
  typedef struct {
    int          cyc;
    logic [25:1] ev;
    logic        done;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  event_encoder_25 #(.p_pix_width(4), .p_tick(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pixels(pix1), .i_valid(v1), .o_ready(r1),
    .i_clear(c1), .o_event(e1), .o_busy(b1), .o_done(d1)
  );
  event_encoder_25 #(.p_pix_width(4), .p_tick(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_pixels(pix2), .i_valid(v2), .o_ready(r2),
    .i_clear(c2), .o_event(e2), .o_busy(b2), .o_done(d2)
  );

  function automatic logic [99:0] px(input int k, input int v);
    logic [99:0] r;
    r = '0;
    r[(k-1)*4 +: 4] = v[3:0];
    return r;
  endfunction

  task automatic push(input int d, input int c, input logic [25:1] ev, input logic done);
    exp_t e;
    e.cyc = c;
    e.ev = ev;
    e.done = done;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int d, input logic [25:1] ev, input logic done);
    exp_t e;
    if (ev == '0 && !done) return;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_output dut%0d cyc=%0d: got ev=%h done=%b, required no output", d + 1, cyc, ev, done);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (e.cyc != cyc || e.ev != ev || e.done != done) begin
      errors++;
      $display("FAIL output_match dut%0d: got cyc=%0d ev=%h done=%b, required cyc=%0d ev=%h done=%b",
               d + 1, cyc, ev, done, e.cyc, e.ev, e.done);
    end
  endtask

  always @(negedge clk) begin
    mon(0, e1, d1);
    mon(1, e2, d2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h, required %h", nm, cyc, act, req);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int base, input int n);
    int guard;
    guard = 0;
    while (cyc < base - 1 + n && guard < 1000) begin
      adv();
      guard++;
    end
  endtask

  task automatic send1(input logic [99:0] px_in, output int acc);
    pix1 = px_in;
    v1 = 1'b1;
    adv();
    v1 = 1'b0;
    acc = cyc;
    chk("busy_after_accept", {31'd0, b1}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0; c1 = 1'b0; c2 = 1'b0; pix1 = '0; pix2 = '0;
    repeat (3) adv();
    rst = 1'b0;
    adv();
    chk("reset_ready", {31'd0, r1}, 32'd1);
    chk("reset_busy", {31'd0, b1}, 32'd0);
    chk("reset_done", {31'd0, d1}, 32'd0);
    chk("reset_event", {7'd0, e1}, 32'd0);

    send1(px(1, 15) | px(25, 1), a);
    push(0, a + 1, 25'h1, 1'b0);
    push(0, a + 57, 25'h1000000, 1'b0);
    push(0, a + 64, 25'h0, 1'b1);
    wait_to(a, 65);
    chk("ready_in_done", {31'd0, r1}, 32'd0);
    chk("done_cycle65", {31'd0, d1}, 32'd1);
    wait_to(a, 66);
    chk("ready_cycle66", {31'd0, r1}, 32'd1);

    p = '0;
    for (int k = 1; k <= 25; k++) p = p | px(k, 8);
    send1(p, a);
    push(0, a + 29, 25'h1FFFFFF, 1'b0);
    push(0, a + 64, 25'h0, 1'b1);
    wait_to(a, 66);
    chk("ready_after_all8", {31'd0, r1}, 32'd1);

    send1('0, a);
    push(0, a + 64, 25'h0, 1'b1);
    wait_to(a, 66);
    chk("ready_after_zero", {31'd0, r1}, 32'd1);

    send1(px(3, 1), a);
    wait_to(a, 20);
    c1 = 1'b1;
    adv();
    c1 = 1'b0;
    chk("clear_ready", {31'd0, r1}, 32'd1);
    chk("clear_busy", {31'd0, b1}, 32'd0);
    pix1 = px(1, 15);
    c1 = 1'b1;
    v1 = 1'b1;
    adv();
    c1 = 1'b0;
    v1 = 1'b0;
    chk("clear_blocks_accept", {31'd0, r1}, 32'd1);
    chk("clear_blocks_busy", {31'd0, b1}, 32'd0);
    repeat (70) adv();

    pix1 = px(1, 15);
    v1 = 1'b1;
    adv();
    a = cyc;
    pix1 = px(2, 15);
    push(0, a + 1, 25'h1, 1'b0);
    push(0, a + 64, 25'h0, 1'b1);
    push(0, a + 67, 25'h2, 1'b0);
    push(0, a + 130, 25'h0, 1'b1);
    wait_to(a, 66);
    chk("held_valid_ready66", {31'd0, r1}, 32'd1);
    adv();
    v1 = 1'b0;
    chk("held_valid_busy67", {31'd0, b1}, 32'd1);
    wait_to(a, 132);
    chk("held_valid_second_end", {31'd0, r1}, 32'd1);

    send1(px(1, 15), a);
    push(0, a + 1, 25'h1, 1'b0);
    wait_to(a, 10);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    chk("midrun_rst_ready", {31'd0, r1}, 32'd1);
    chk("midrun_rst_busy", {31'd0, b1}, 32'd0);
    chk("midrun_rst_done", {31'd0, d1}, 32'd0);
    chk("midrun_rst_event", {7'd0, e1}, 32'd0);
    repeat (70) adv();

    pix2 = px(1, 15) | px(2, 14);
    v2 = 1'b1;
    adv();
    v2 = 1'b0;
    a = cyc;
    push(1, a + 1, 25'h1, 1'b0);
    push(1, a + 2, 25'h2, 1'b0);
    push(1, a + 16, 25'h0, 1'b1);
    wait_to(a, 17);
    chk("tick1_done17", {31'd0, d2}, 32'd1);
    wait_to(a, 18);
    chk("tick1_ready18", {31'd0, r2}, 32'd1);

    repeat (3) adv();
    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
